// File: rtl/dma_burst_scheduler.sv
// DMA burst scheduler: takes one copy job at a time and splits it into bursts
// that never cross a 4 KiB page on either address, with bounded outstanding count.
module dma_burst_scheduler #(
  parameter int AddrWidth      = 64,
  parameter int LenWidth       = 32,
  parameter int MaxBurstBytes  = 2048,
  parameter int MaxOutstanding = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               job_valid_i,
  output logic                               job_ready_o,
  input  logic [AddrWidth-1:0]               job_src_i,
  input  logic [AddrWidth-1:0]               job_dst_i,
  input  logic [LenWidth-1:0]                job_len_i,
  output logic                               burst_valid_o,
  input  logic                               burst_ready_i,
  output logic [AddrWidth-1:0]               burst_src_o,
  output logic [AddrWidth-1:0]               burst_dst_o,
  output logic [$clog2(MaxBurstBytes):0]     burst_len_o,
  output logic                               burst_last_o,
  input  logic                               burst_done_i,
  input  logic                               irq_en_i,
  input  logic                               irq_clear_i,
  output logic                               busy_o,
  output logic                               job_done_o,
  output logic                               irq_o,
  output logic                               err_o,
  output logic [31:0]                        jobs_completed_o
);

  localparam int BLW = $clog2(MaxBurstBytes) + 1;
  localparam int OW  = $clog2(MaxOutstanding + 1);
  localparam logic [12:0] PAGE      = 13'd4096;
  localparam logic [12:0] MAX_BURST = 13'(MaxBurstBytes);

  typedef enum logic [1:0] {IDLE, SPLIT, DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  init_q;
  logic [AddrWidth-1:0]  src_q, dst_q;
  logic [LenWidth-1:0]   rem_q;
  logic [OW-1:0]         out_q;
  logic                  zero_done_q, irq_q, err_q;
  logic [31:0]           jobs_q;

  logic [12:0] rem_cap, src_room, dst_room, chunk;
  logic        accept, handshake, last, drain_done, done_ok;

  // Chunk is the tightest of remaining bytes, both page rooms and the burst cap,
  // all held in 13 bits so a full 4096-byte room is representable.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rem_cap  = (rem_q > LenWidth'(PAGE)) ? PAGE : rem_q[12:0];
    src_room = PAGE - {1'b0, src_q[11:0]};
    dst_room = PAGE - {1'b0, dst_q[11:0]};
    chunk    = rem_cap;
    if (src_room < chunk)  chunk = src_room;
    if (dst_room < chunk)  chunk = dst_room;
    if (MAX_BURST < chunk) chunk = MAX_BURST;
  end

  assign job_ready_o   = init_q && (state_q == IDLE);
  assign accept        = job_valid_i && job_ready_o;
  assign burst_valid_o = (state_q == SPLIT) && (out_q < OW'(MaxOutstanding));
  assign handshake     = burst_valid_o && burst_ready_i;
  assign last          = (LenWidth'(chunk) == rem_q);
  assign drain_done    = (state_q == DRAIN) && (out_q == '0);
  assign done_ok       = burst_done_i && (out_q != '0);

  assign burst_src_o      = src_q;
  assign burst_dst_o      = dst_q;
  assign burst_len_o      = chunk[BLW-1:0];
  assign burst_last_o     = last;
  assign busy_o           = (state_q != IDLE);
  assign job_done_o       = zero_done_q || drain_done;
  assign irq_o            = irq_q;
  assign err_o            = err_q;
  assign jobs_completed_o = jobs_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && (job_len_i != '0)) state_d = SPLIT;
      SPLIT:   if (handshake && last)           state_d = DRAIN;
      DRAIN:   if (out_q == '0)                 state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q     <= IDLE;
      init_q      <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      out_q       <= '0;
      zero_done_q <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
      jobs_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_q      <= 1'b1;
      zero_done_q <= accept && (job_len_i == '0);

      if (accept) begin
        src_q <= job_src_i;
        dst_q <= job_dst_i;
        rem_q <= job_len_i;
      end else if (handshake) begin
        src_q <= src_q + AddrWidth'(chunk);
        dst_q <= dst_q + AddrWidth'(chunk);
        rem_q <= rem_q - LenWidth'(chunk);
      end

      // A stray completion with nothing outstanding is dropped and flagged.
      unique case ({handshake, done_ok})
        2'b10:   out_q <= out_q + 1'b1;
        2'b01:   out_q <= out_q - 1'b1;
        default: out_q <= out_q;
      endcase
      if (burst_done_i && (out_q == '0)) err_q <= 1'b1;

      if (job_done_o) jobs_q <= jobs_q + 32'd1;

      if (job_done_o && irq_en_i) irq_q <= 1'b1;
      else if (irq_clear_i)       irq_q <= 1'b0;
    end
  end

endmodule
